tlb_op_ctrl: RTL and testbench

- Initiator side of the MMU TLB maintenance interface.
- Accepts one TLB instruction at a time (TLBR, TLBWI, TLBWR, TLBP) from the CP0/execute stage and sequences the request onto the MMU ports: tlbrw_index/we/wdata, tlbrw_rdata, tlbp_entry_hi, tlbp_index.
- Returns registered results to CP0 and maintains the architectural Random register.

---
 rtl/tlb_op_ctrl.sv | 165 ++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBR/TLBWI/TLBWR/TLBP onto the MMU TLB ports and keeps CP0 Random.
// Optional duplicate-entry probe before writes when TLB_DUP_CHECK_EN is defined.
package tlb_op_ctrl_pkg;
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;
endpackage

module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int INDEX_WIDTH = $clog2(TLB_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  input  logic [1:0]             op_code,
  output logic                   op_ready,
  output logic                   done,
  output logic                   mcheck,
  input  logic [31:0]            cp0_index,
  input  logic [31:0]            cp0_entry_hi,
  input  logic [31:0]            cp0_entry_lo0,
  input  logic [31:0]            cp0_entry_lo1,
  input  logic [INDEX_WIDTH-1:0] cp0_wired,
  input  logic                   wired_we,
  output logic [INDEX_WIDTH-1:0] random,
  output logic [INDEX_WIDTH-1:0] tlbrw_index,
  output logic                   tlbrw_we,
  output tlb_entry_t             tlbrw_wdata,
  input  tlb_entry_t             tlbrw_rdata,
  output logic [31:0]            tlbp_entry_hi,
  input  logic [31:0]            tlbp_index,
  output logic [31:0]            res_entry_hi,
  output logic [31:0]            res_entry_lo0,
  output logic [31:0]            res_entry_lo1,
  output logic [31:0]            res_index,
  output logic                   res_read_we,
  output logic                   res_probe_we
);
  localparam logic [INDEX_WIDTH-1:0] MAX_IDX = INDEX_WIDTH'(TLB_ENTRIES - 1);
  localparam logic [1:0] OP_TLBR = 2'd0, OP_TLBWI = 2'd1, OP_TLBWR = 2'd2, OP_TLBP = 2'd3;
`ifdef TLB_DUP_CHECK_EN
  typedef enum logic [1:0] {IDLE, EXEC, DONE, CHECK} state_e;
  logic mchk_q, mchk_d;
`else
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
`endif
  state_e state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d, random_q, random_d;
  logic [31:0] eh_q, eh_d, res_hi_q, res_hi_d, res_lo0_q, res_lo0_d, res_lo1_q, res_lo1_d, res_idx_q, res_idx_d;
  tlb_entry_t wd_q, wd_d;
  logic is_wr;
  logic unused;
  assign unused = ^{cp0_index[31:INDEX_WIDTH], cp0_entry_lo0[31:26], cp0_entry_lo1[31:26]};
  assign is_wr = op_q == OP_TLBWI || op_q == OP_TLBWR;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    idx_d = idx_q;
    eh_d = eh_q;
    wd_d = wd_q;
    res_hi_d = res_hi_q;
    res_lo0_d = res_lo0_q;
    res_lo1_d = res_lo1_q;
    res_idx_d = res_idx_q;
`ifdef TLB_DUP_CHECK_EN
    mchk_d = mchk_q;
`endif
    // Reload also covers random sitting below a freshly raised Wired
    random_d = (wired_we || random_q <= cp0_wired) ? MAX_IDX : random_q - 1'b1;
    case (state_q)
      IDLE: if (op_valid) begin
        op_d = op_code;
        idx_d = op_code == OP_TLBWR ? random_q : cp0_index[INDEX_WIDTH-1:0];
        eh_d = cp0_entry_hi;
        wd_d = {cp0_entry_hi[31:13], cp0_entry_hi[7:0], cp0_entry_lo0[0] & cp0_entry_lo1[0],
                cp0_entry_lo0[25:1], cp0_entry_lo1[25:1]};
`ifdef TLB_DUP_CHECK_EN
        mchk_d = 1'b0;
        state_d = (op_code == OP_TLBWI || op_code == OP_TLBWR) ? CHECK : EXEC;
`else
        state_d = EXEC;
`endif
      end
      EXEC: begin
        state_d = DONE;
        if (op_q == OP_TLBR) begin
          res_hi_d = {tlbrw_rdata.vpn2, 5'b0, tlbrw_rdata.asid};
          res_lo0_d = {6'b0, tlbrw_rdata.pfn0, tlbrw_rdata.c0, tlbrw_rdata.d0, tlbrw_rdata.v0, tlbrw_rdata.g};
          res_lo1_d = {6'b0, tlbrw_rdata.pfn1, tlbrw_rdata.c1, tlbrw_rdata.d1, tlbrw_rdata.v1, tlbrw_rdata.g};
        end
        if (op_q == OP_TLBP) res_idx_d = tlbp_index;
      end
`ifdef TLB_DUP_CHECK_EN
      CHECK: begin
        mchk_d = !tlbp_index[31] && tlbp_index[INDEX_WIDTH-1:0] != idx_q;
        state_d = mchk_d ? DONE : EXEC;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q <= 2'd0;
      idx_q <= '0;
      eh_q <= '0;
      wd_q <= '0;
      res_hi_q <= '0;
      res_lo0_q <= '0;
      res_lo1_q <= '0;
      res_idx_q <= '0;
      random_q <= MAX_IDX;
`ifdef TLB_DUP_CHECK_EN
      mchk_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      idx_q <= idx_d;
      eh_q <= eh_d;
      wd_q <= wd_d;
      res_hi_q <= res_hi_d;
      res_lo0_q <= res_lo0_d;
      res_lo1_q <= res_lo1_d;
      res_idx_q <= res_idx_d;
      random_q <= random_d;
`ifdef TLB_DUP_CHECK_EN
      mchk_q <= mchk_d;
`endif
    end
  end
  assign op_ready = state_q == IDLE;
  assign done = state_q == DONE;
  assign tlbrw_we = state_q == EXEC && is_wr;
  assign res_read_we = done && op_q == OP_TLBR;
  assign res_probe_we = done && op_q == OP_TLBP;
`ifdef TLB_DUP_CHECK_EN
  assign mcheck = done && mchk_q;
`else
  assign mcheck = 1'b0;
`endif
  assign random = random_q;
  assign tlbrw_index = idx_q;
  assign tlbrw_wdata = wd_q;
  assign tlbp_entry_hi = eh_q;
  assign res_entry_hi = res_hi_q;
  assign res_entry_lo0 = res_lo0_q;
  assign res_entry_lo1 = res_lo1_q;
  assign res_index = res_idx_q;
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed stimulus with a queue-based scoreboard for tlb_op_ctrl.
module tb_tlb_op_ctrl;
  import tlb_op_ctrl_pkg::*;
  localparam int N = 16;
  localparam int IW = 4;
`ifdef TLB_DUP_CHECK_EN
  localparam int WLAT = 1;
`else
  localparam int WLAT = 0;
`endif
  logic clk, rst, op_valid, op_ready, done, mcheck, wired_we, tlbrw_we, res_read_we, res_probe_we;
  logic [1:0] op_code;
  logic [31:0] cp0_index, cp0_entry_hi, cp0_entry_lo0, cp0_entry_lo1, tlbp_entry_hi, tlbp_index;
  logic [31:0] res_entry_hi, res_entry_lo0, res_entry_lo1, res_index, probe_ret;
  logic [IW-1:0] cp0_wired, random, tlbrw_index;
  tlb_entry_t tlbrw_wdata, tlbrw_rdata, e1, e2;
  tlb_entry_t mem [N];
  int total = 0, bad = 0, cyc = 0, a;

  typedef struct {int cyc; logic [IW-1:0] idx; tlb_entry_t wd;} wr_t;
  typedef struct {int cyc; bit rd; bit pr; bit mc; logic [31:0] eh, hi, lo0, lo1, idx;} dn_t;
  wr_t wq[$];
  dn_t dq[$];

  tlb_op_ctrl #(.TLB_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .done(done), .mcheck(mcheck), .cp0_index(cp0_index), .cp0_entry_hi(cp0_entry_hi),
    .cp0_entry_lo0(cp0_entry_lo0), .cp0_entry_lo1(cp0_entry_lo1), .cp0_wired(cp0_wired),
    .wired_we(wired_we), .random(random), .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we),
    .tlbrw_wdata(tlbrw_wdata), .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi),
    .tlbp_index(tlbp_index), .res_entry_hi(res_entry_hi), .res_entry_lo0(res_entry_lo0),
    .res_entry_lo1(res_entry_lo1), .res_index(res_index), .res_read_we(res_read_we),
    .res_probe_we(res_probe_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MMU model: synchronous write, combinational read and probe
  initial for (int i = 0; i < N; i++) mem[i] = '0;
  always @(posedge clk) if (tlbrw_we) mem[tlbrw_index] <= tlbrw_wdata;
  assign tlbrw_rdata = mem[tlbrw_index];
  assign tlbp_index = probe_ret;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_done(input int c, input bit rd, input bit pr, input bit mc,
                           input logic [31:0] eh, hi, lo0, lo1, idx);
    dn_t d;
    d.cyc = c; d.rd = rd; d.pr = pr; d.mc = mc;
    d.eh = eh; d.hi = hi; d.lo0 = lo0; d.lo1 = lo1; d.idx = idx;
    dq.push_back(d);
  endtask

  task automatic push_wr(input int c, input logic [IW-1:0] idx, input tlb_entry_t wd);
    wr_t w;
    w.cyc = c; w.idx = idx; w.wd = wd;
    wq.push_back(w);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] idx, eh, lo0, lo1, probe, output int acc);
    int n = 0;
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", n < 20, 1'b1);
    op_valid = 1'b1; op_code = op; cp0_index = idx;
    cp0_entry_hi = eh; cp0_entry_lo0 = lo0; cp0_entry_lo1 = lo1; probe_ret = probe;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    acc = cyc;
  endtask

  always @(negedge clk) begin : mon
    wr_t w;
    dn_t d;
    if (rst && tlbrw_we) begin
      chk("write_expected", wq.size() != 0, 1'b1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("wr_cycle", cyc, w.cyc);
        chk("wr_index", tlbrw_index, w.idx);
        chk("wr_data", tlbrw_wdata, w.wd);
      end
    end
    if (rst && done) begin
      chk("done_expected", dq.size() != 0, 1'b1);
      if (dq.size() != 0) begin
        d = dq.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("res_read_we", res_read_we, d.rd);
        chk("res_probe_we", res_probe_we, d.pr);
        chk("mcheck", mcheck, d.mc);
        chk("tlbp_entry_hi", tlbp_entry_hi, d.eh);
        if (d.rd) begin
          chk("res_entry_hi", res_entry_hi, d.hi);
          chk("res_entry_lo0", res_entry_lo0, d.lo0);
          chk("res_entry_lo1", res_entry_lo1, d.lo1);
        end
        if (d.pr) chk("res_index", res_index, d.idx);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    e1 = '{vpn2: 19'h201, asid: 8'h03, g: 1'b0, pfn0: 20'h48D15, c0: 3'd4, d0: 1'b1, v0: 1'b1,
           pfn1: 20'h0, c1: 3'd2, d1: 1'b1, v1: 1'b1};
    e2 = '{vpn2: 19'h7FFFF, asid: 8'hFF, g: 1'b1, pfn0: 20'hFFFFF, c0: 3'd7, d0: 1'b1, v0: 1'b1,
           pfn1: 20'h0, c1: 3'd0, d1: 1'b0, v1: 1'b0};
    rst = 1'b0; op_valid = 1'b0; op_code = 2'd0; wired_we = 1'b0; cp0_wired = '0;
    cp0_index = '0; cp0_entry_hi = '0; cp0_entry_lo0 = '0; cp0_entry_lo1 = '0;
    probe_ret = 32'h8000_0000;
    repeat (2) @(negedge clk);
    chk("rst_op_ready", op_ready, 1'b1);
    chk("rst_random", random, 4'd15);
    chk("rst_done", done, 1'b0);
    chk("rst_tlbrw_we", tlbrw_we, 1'b0);
    chk("rst_read_we", res_read_we, 1'b0);
    chk("rst_probe_we", res_probe_we, 1'b0);
    chk("rst_mcheck", mcheck, 1'b0);
    chk("rst_tlbrw_index", tlbrw_index, 4'd0);
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      chk("random_wired0", random, 15 - (i % 16));
    end
    cp0_wired = 4'd4;
    for (int j = 0; j < 13; j++) begin
      if (j > 0) @(negedge clk);
      chk("random_wired4", random, j < 12 ? 15 - j : 15);
    end
    repeat (6) @(negedge clk);
    chk("random_at9", random, 4'd9);
    wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
    chk("random_wired_we", random, 4'd15);
    cp0_wired = 4'd15;
    repeat (3) begin
      @(negedge clk);
      chk("random_saturated", random, 4'd15);
    end
    cp0_wired = 4'd0;
    @(negedge clk);
    // TLBWI to index 5, combined G is lo0.G & lo1.G = 0
    issue(2'd1, 32'd5, 32'h0040_2003, 32'h0123_4567, 32'h0000_0016, 32'h8000_0000, a);
    push_wr(a + WLAT, 4'd5, e1);
    push_done(a + 1 + WLAT, 1'b0, 1'b0, 1'b0, 32'h0040_2003, 0, 0, 0, 0);
    for (int k = 0; k < 2 + WLAT; k++) begin
      @(negedge clk);
      chk("busy_op_ready", op_ready, 1'b0);
    end
    @(negedge clk);
    chk("idle_op_ready", op_ready, 1'b1);
    issue(2'd0, 32'd5, 32'h0, 32'h0, 32'h0, 32'h8000_0000, a);
    push_done(a + 1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_2003, 32'h0123_4566, 32'h0000_0016, 0);
    issue(2'd3, 32'd0, 32'h1234_6042, 32'h0, 32'h0, 32'h8000_0000, a);
    push_done(a + 1, 1'b0, 1'b1, 1'b0, 32'h1234_6042, 0, 0, 0, 32'h8000_0000);
    issue(2'd3, 32'd0, 32'h0040_2003, 32'h0, 32'h0, 32'h0000_0005, a);
    push_done(a + 1, 1'b0, 1'b1, 1'b0, 32'h0040_2003, 0, 0, 0, 32'h0000_0005);
    n = 0;
    while (!(op_ready && random == 4'd7) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_random7", n < 40, 1'b1);
    issue(2'd2, 32'd0, 32'hFFFF_E0FF, 32'h03FF_FFFF, 32'h0000_0001, 32'h8000_0000, a);
    push_wr(a + WLAT, 4'd7, e2);
    push_done(a + 1 + WLAT, 1'b0, 1'b0, 1'b0, 32'hFFFF_E0FF, 0, 0, 0, 0);
    issue(2'd0, 32'd7, 32'h0, 32'h0, 32'h0, 32'h8000_0000, a);
    push_done(a + 1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_E0FF, 32'h03FF_FFFF, 32'h0000_0001, 0);
`ifdef TLB_DUP_CHECK_EN
    issue(2'd1, 32'd3, 32'h0040_2003, 32'h0123_4567, 32'h0000_0016, 32'h0000_0005, a);
    push_done(a + 1, 1'b0, 1'b0, 1'b1, 32'h0040_2003, 0, 0, 0, 0);
    issue(2'd1, 32'd3, 32'h0040_2003, 32'h0123_4567, 32'h0000_0016, 32'h0000_0003, a);
    push_wr(a + 1, 4'd3, e1);
    push_done(a + 2, 1'b0, 1'b0, 1'b0, 32'h0040_2003, 0, 0, 0, 0);
`endif
    issue(2'd1, 32'd9, 32'h0040_2003, 32'h0123_4567, 32'h0000_0016, 32'h8000_0000, a);
    repeat (WLAT) begin
      @(posedge clk);
      #1;
    end
    chk("we_before_reset", tlbrw_we, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("we_async_drop", tlbrw_we, 1'b0);
    chk("ready_in_reset", op_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    chk("random_after_reset", random, 4'd15);
    @(negedge clk);
    chk("ready_after_reset", op_ready, 1'b1);
    chk("done_after_reset", done, 1'b0);
    repeat (4) @(negedge clk);
    chk("aborted_write_mem9", mem[9], '0);
    chk("write_queue_drained", wq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
